// File: rtl/bfp_max_bw_detector_if.sv
// Sample-stream and report bundle of the BFP max bit-width detector.
// Ports: init_start/stage_start/valid/data_re/data_im flow into the detector;
//        init/bw_init/update/bw_new/busy/err flow back to the pass controller.
// The slave modport is the detector side; master is the feeder/controller side.
interface bfp_max_bw_detector_if #(
  parameter int FFT_DW            = 16,
  parameter int FFT_MAX_BIT_WIDTH = 5
) ();

  logic                         init_start;
  logic                         stage_start;
  logic                         valid;
  logic signed [FFT_DW-1:0]     data_re;
  logic signed [FFT_DW-1:0]     data_im;
  logic                         init;
  logic [FFT_MAX_BIT_WIDTH-1:0] bw_init;
  logic                         update;
  logic [FFT_MAX_BIT_WIDTH-1:0] bw_new;
  logic                         busy;
  logic                         err;

  modport slave (
    input  init_start, stage_start, valid, data_re, data_im,
    output init, bw_init, update, bw_new, busy, err
  );

  modport master (
    output init_start, stage_start, valid, data_re, data_im,
    input  init, bw_init, update, bw_new, busy, err
  );

endinterface

// File: rtl/bfp_max_bw_detector.sv
// Purpose: largest signed bit width over one FFT pass of POINTS complex samples.
// Latency: report pulse two cycles after the POINTS-th accepted sample.
// Backpressure: none; samples are taken whenever valid, protocol misuse sets err.
//
// Ports: clk, reset (synchronous, active-high) and the slave side of
// bfp_max_bw_detector_if (start pulses, sample stream in; init/update report
// pulses with bw_init/bw_new, busy and sticky err out).
module bfp_max_bw_detector #(
  parameter int FFT_MAX_BIT_WIDTH = 5,
  parameter int FFT_DW            = 16,
  parameter int POINTS            = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  bfp_max_bw_detector_if.slave    bus
);

  // One extra bit so the counter can hold POINTS itself and saturate there.
  localparam int                CNT_W    = $clog2(POINTS) + 1;
  localparam logic [CNT_W-1:0]  POINTS_C = CNT_W'(POINTS);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(POINTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_next;

  logic                         mode_init;
  logic [CNT_W-1:0]             count;
  logic [FFT_MAX_BIT_WIDTH-1:0] acc;
  logic [FFT_MAX_BIT_WIDTH-1:0] s_reg;
  logic                         s_vld;

  logic                         init_q;
  logic                         update_q;
  logic [FFT_MAX_BIT_WIDTH-1:0] bw_init_q;
  logic [FFT_MAX_BIT_WIDTH-1:0] bw_new_q;
  logic                         err_q;

  logic                         start_any;
  logic                         start_ok;
  logic                         accept;
  logic                         last;
  logic [FFT_MAX_BIT_WIDTH-1:0] bw_re;
  logic [FFT_MAX_BIT_WIDTH-1:0] bw_im;
  logic [FFT_MAX_BIT_WIDTH-1:0] s_comb;
  logic [FFT_MAX_BIT_WIDTH-1:0] acc_next;
  logic                         busy_c;

  // Signed bit width including the sign bit. Folding negatives with ~x makes
  // 0 and -1 both collapse to m=0 (width 0); otherwise it is msb(m)+2.
  // The top bit of m is always zero, so the scan stops one short of it.
  function automatic logic [FFT_MAX_BIT_WIDTH-1:0] bit_width(
    input logic [FFT_DW-1:0] x
  );
    logic [FFT_DW-1:0]            m;
    logic [FFT_MAX_BIT_WIDTH-1:0] r;
    m = x[FFT_DW-1] ? ~x : x;
    r = '0;
    for (int i = 0; i < FFT_DW - 1; i++) begin
      if (m[i]) begin
        r = FFT_MAX_BIT_WIDTH'(i + 2);
      end
    end
    return r;
  endfunction

  assign start_any = bus.init_start | bus.stage_start;
  assign start_ok  = (state == IDLE) && start_any;
  assign accept    = (state == ACC) && bus.valid;
  assign last      = accept && (count == LAST_C);

  assign bw_re     = bit_width(bus.data_re);
  assign bw_im     = bit_width(bus.data_im);
  assign s_comb    = (bw_re > bw_im) ? bw_re : bw_im;

  // Running max including whatever sample width sits in the pipeline stage;
  // in DRAIN this is the final pass result and is reported directly.
  assign acc_next  = (s_vld && (s_reg > acc)) ? s_reg : acc;

  // Next-state and combinational outputs.
  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start_any) begin
          state_next = ACC;
        end
      end
      ACC: begin
        busy_c = 1'b1;
        if (last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: counter, width pipeline, running max, report and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_init <= 1'b0;
      count     <= '0;
      acc       <= '0;
      s_reg     <= '0;
      s_vld     <= 1'b0;
      init_q    <= 1'b0;
      update_q  <= 1'b0;
      bw_init_q <= '0;
      bw_new_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      // Stage 1: register the per-sample width.
      s_vld <= accept;
      if (accept) begin
        s_reg <= s_comb;
      end

      // A new pass clears the count and max; init_start takes precedence.
      if (start_ok) begin
        mode_init <= bus.init_start;
        count     <= '0;
        acc       <= '0;
      end else begin
        if (accept && (count != POINTS_C)) begin
          count <= count + 1'b1;
        end
        // Stage 2: fold the registered width into the running max.
        acc <= acc_next;
      end

      // Report pulses last one cycle; the idle-side width output holds.
      init_q   <= 1'b0;
      update_q <= 1'b0;
      if (state == DRAIN) begin
        if (mode_init) begin
          init_q    <= 1'b1;
          bw_init_q <= acc_next;
        end else begin
          update_q  <= 1'b1;
          bw_new_q  <= acc_next;
        end
      end

      // Starts while busy are dropped and flagged; samples arriving after the
      // pass is full are dropped and flagged. Valid while idle is harmless.
      if (((state != IDLE) && start_any) || ((state == DRAIN) && bus.valid)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.init    = init_q;
  assign bus.update  = update_q;
  assign bus.bw_init = bw_init_q;
  assign bus.bw_new  = bw_new_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_c;

endmodule

// File: tb/tb_bfp_max_bw_detector.sv
// Directed testbench for bfp_max_bw_detector with a pass-level reference model.
// Inputs are driven on the falling edge; outputs are compared 1 time unit after
// each rising edge against the model, plus literal checks between phases.
module tb_bfp_max_bw_detector;

  localparam int DW     = 16;
  localparam int BW     = 5;
  localparam int POINTS = 8;

  logic clk;
  logic reset;

  int checks;
  int errors;
  int n_init;
  int n_update;

  bfp_max_bw_detector_if #(.FFT_DW(DW), .FFT_MAX_BIT_WIDTH(BW)) bus ();

  bfp_max_bw_detector #(
    .FFT_MAX_BIT_WIDTH (BW),
    .FFT_DW            (DW),
    .POINTS            (POINTS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference width: smallest two's-complement width that holds x, with the
  // degenerate values 0 and -1 reported as zero.
  function automatic int mbw(input int x);
    if (x == 0 || x == -1) return 0;
    for (int w = 2; w <= 32; w++) begin
      if (longint'(x) >= -(longint'(1) << (w - 1)) && longint'(x) < (longint'(1) << (w - 1)))
        return w;
    end
    return 32;
  endfunction

  // ---------------- pass-level model ----------------
  bit m_ready;
  bit m_busy;
  bit m_collect;
  bit m_mode_init;
  int m_cnt;
  int m_max;
  bit exp_init;
  bit exp_update;
  int exp_bw_init;
  int exp_bw_new;
  bit exp_err;

  always @(posedge clk) begin
    int s;
    if (reset) begin
      m_ready     = 1'b1;
      m_busy      = 1'b0;
      m_collect   = 1'b0;
      m_cnt       = 0;
      m_max       = 0;
      exp_init    = 1'b0;
      exp_update  = 1'b0;
      exp_bw_init = 0;
      exp_bw_new  = 0;
      exp_err     = 1'b0;
    end else if (m_ready) begin
      exp_init   = 1'b0;
      exp_update = 1'b0;
      if (m_busy) begin
        if (bus.init_start || bus.stage_start) exp_err = 1'b1;
        if (m_collect) begin
          if (bus.valid) begin
            s = mbw(int'(bus.data_re));
            if (mbw(int'(bus.data_im)) > s) s = mbw(int'(bus.data_im));
            if (s > m_max) m_max = s;
            m_cnt++;
            if (m_cnt == POINTS) m_collect = 1'b0;
          end
        end else begin
          // Pass full: this edge ends the settle cycle and emits the report.
          if (bus.valid) exp_err = 1'b1;
          if (m_mode_init) begin
            exp_init    = 1'b1;
            exp_bw_init = m_max;
          end else begin
            exp_update  = 1'b1;
            exp_bw_new  = m_max;
          end
          m_busy = 1'b0;
        end
      end else if (bus.init_start || bus.stage_start) begin
        m_busy      = 1'b1;
        m_collect   = 1'b1;
        m_mode_init = bus.init_start;
        m_cnt       = 0;
        m_max       = 0;
      end
    end
  end

  // ---------------- cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (m_ready) begin
      chk("cmp_init",    int'(bus.init),    int'(exp_init));
      chk("cmp_update",  int'(bus.update),  int'(exp_update));
      chk("cmp_bw_init", int'(bus.bw_init), exp_bw_init);
      chk("cmp_bw_new",  int'(bus.bw_new),  exp_bw_new);
      chk("cmp_busy",    int'(bus.busy),    int'(m_busy));
      chk("cmp_err",     int'(bus.err),     int'(exp_err));
      if (bus.init === 1'b1 && bus.update === 1'b1) begin
        chk("cmp_both_pulses", 1, 0);
      end
      if (bus.init === 1'b1)   n_init++;
      if (bus.update === 1'b1) n_update++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic is, input logic ss, input logic v,
                     input int re, input int im);
    bus.init_start  = is;
    bus.stage_start = ss;
    bus.valid       = v;
    bus.data_re     = DW'(re);
    bus.data_im     = DW'(im);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  int re1 [8] = '{1, 0, -1, 3, 0, 0, 0, 0};
  int re2 [8] = '{1, 2, -1, 0, 3, -32768, 5, 0};
  int snap;

  initial begin
    checks   = 0;
    errors   = 0;
    n_init   = 0;
    n_update = 0;
    reset    = 1'b1;
    bus.init_start  = 1'b0;
    bus.stage_start = 1'b0;
    bus.valid       = 1'b0;
    bus.data_re     = '0;
    bus.data_im     = '0;

    // Reference model pins
    chk("mdl_bw_4000", mbw(16384), 16);
    chk("mdl_bw_m8000", mbw(-32768), 16);
    chk("mdl_bw_m2", mbw(-2), 2);
    chk("mdl_bw_m1", mbw(-1), 0);
    chk("mdl_bw_3", mbw(3), 3);

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_bw_init", int'(bus.bw_init), 0);
    chk("rst_bw_new", int'(bus.bw_new), 0);
    reset = 1'b0;
    idle(2);

    // ADC load pass
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, re1[i], 0);
    chk("p1_busy_drain", int'(bus.busy), 1);
    idle(1);
    chk("p1_init", int'(bus.init), 1);
    chk("p1_bw_init", int'(bus.bw_init), 3);
    chk("p1_update", int'(bus.update), 0);
    chk("p1_bw_new", int'(bus.bw_new), 0);
    chk("p1_busy_pulse", int'(bus.busy), 0);
    idle(2);

    // Stage pass with a full-scale negative sample
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, re2[i], 1);
    idle(1);
    chk("p2_update", int'(bus.update), 1);
    chk("p2_bw_new", int'(bus.bw_new), 16);
    chk("p2_bw_init_hold", int'(bus.bw_init), 3);
    chk("p2_init", int'(bus.init), 0);
    idle(2);

    // Stage pass with valid toggling
    snap = n_update;
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, (i % 2) == 0, 0, 255);
    chk("p3_update", int'(bus.update), 1);
    chk("p3_bw_new", int'(bus.bw_new), 9);
    idle(2);
    chk("p3_one_update", n_update - snap, 1);

    // Back-to-back passes, restart in the pulse cycle
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 7, -3);
    idle(1);
    chk("p4_update", int'(bus.update), 1);
    chk("p4_bw_new", int'(bus.bw_new), 4);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    chk("p4_restart_busy", int'(bus.busy), 1);
    chk("p4_restart_err", int'(bus.err), 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 0, 0);
    idle(1);
    chk("p5_update", int'(bus.update), 1);
    chk("p5_bw_new", int'(bus.bw_new), 0);
    idle(2);

    // Both starts together: INIT mode wins
    snap = n_update;
    cyc(1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 0, -9);
    idle(1);
    chk("p6_init", int'(bus.init), 1);
    chk("p6_bw_init", int'(bus.bw_init), 5);
    chk("p6_bw_new_hold", int'(bus.bw_new), 0);
    idle(2);
    chk("p6_no_update", n_update - snap, 0);

    // init_start while busy: flagged, pass unaffected
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1, 0);
    cyc(1'b1, 1'b0, 1'b1, 256, 0);
    chk("p7_err_set", int'(bus.err), 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1, 0);
    idle(1);
    chk("p7_init", int'(bus.init), 1);
    chk("p7_bw_init", int'(bus.bw_init), 10);
    idle(2);
    chk("p7_err_sticky", int'(bus.err), 1);

    // Reset mid-pass aborts without a report
    snap = n_init + n_update;
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 100, 0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);
    chk("p8_no_pulse", n_init + n_update - snap, 0);
    chk("p8_err", int'(bus.err), 0);
    chk("p8_busy", int'(bus.busy), 0);
    chk("p8_bw_init", int'(bus.bw_init), 0);
    chk("p8_bw_new", int'(bus.bw_new), 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 16, 0);
    idle(1);
    chk("p9_update", int'(bus.update), 1);
    chk("p9_bw_new", int'(bus.bw_new), 6);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
